// File: rtl/pdp8_seq_pkg.sv
// ============================================================================
// Module  : pdp8_seq_pkg
// Brief   : Shared types and constants for the PDP-8 phase sequencer.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package pdp8_seq_pkg;

    localparam int SEQ_MAX_PHASES = 6;
    localparam int ICOUNT_W       = 12;

    // Execute states interleave as C1,S1,C2,S2,...: odd codes are ck states.
    typedef enum logic [3:0] {
        IDLE = 4'd0,
        FCK  = 4'd1,
        FSTB = 4'd2,
        C1   = 4'd3,
        S1   = 4'd4,
        C2   = 4'd5,
        S2   = 4'd6,
        C3   = 4'd7,
        S3   = 4'd8,
        C4   = 4'd9,
        S4   = 4'd10,
        C5   = 4'd11,
        S5   = 4'd12,
        C6   = 4'd13,
        S6   = 4'd14
    } seq_state_t;

    // Zero-based phase number of a C or S state.
    function automatic logic [2:0] seq_phase_idx(input seq_state_t s);
        return 3'((4'(s) - 4'd3) >> 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/phase_sequencer_if.sv
// ============================================================================
// Module  : phase_sequencer_if
// Brief   : Control, fetch handshake and phase outputs of the sequencer.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface phase_sequencer_if;

    logic                                run;
    logic                                halt_req;
    logic                                step;
    logic                                mem_ready;
    logic                                done;
    logic                                fetch_ck;
    logic                                fetch_stb;
    logic [pdp8_seq_pkg::SEQ_MAX_PHASES-1:0] ck;
    logic [pdp8_seq_pkg::SEQ_MAX_PHASES-1:0] stb;
    logic                                running;
    logic                                seq_err;
    logic [pdp8_seq_pkg::ICOUNT_W-1:0]   icount;

    modport master (
        input  run, halt_req, step, mem_ready, done,
        output fetch_ck, fetch_stb, ck, stb, running, seq_err, icount
    );

    modport slave (
        output run, halt_req, step, mem_ready, done,
        input  fetch_ck, fetch_stb, ck, stb, running, seq_err, icount
    );

endinterface

`default_nettype wire

// File: rtl/seq_phase_decode.sv
// ============================================================================
// Module  : seq_phase_decode
// Brief   : Moore decode of the sequencer state into phase clocks/strobes.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module seq_phase_decode
    import pdp8_seq_pkg::*;
#(
    parameter int NPHASES = 6
) (
    input  seq_state_t                state,
    output logic                      fetch_ck,
    output logic                      fetch_stb,
    output logic [SEQ_MAX_PHASES-1:0] ck,
    output logic [SEQ_MAX_PHASES-1:0] stb,
    output logic                      running
);

    localparam logic [SEQ_MAX_PHASES-1:0] PHASE_MASK =
        SEQ_MAX_PHASES'((1 << NPHASES) - 1);

    logic [SEQ_MAX_PHASES-1:0] ck_raw;
    logic [SEQ_MAX_PHASES-1:0] stb_raw;

    always_comb begin
        fetch_ck  = (state == FCK);
        fetch_stb = (state == FSTB);
        running   = (state != IDLE);
        ck_raw    = '0;
        stb_raw   = '0;
        if (state >= C1 && state <= S6) begin
            if (state[0]) begin
                ck_raw[seq_phase_idx(state)] = 1'b1;
            end else begin
                stb_raw[seq_phase_idx(state)] = 1'b1;
            end
        end
        ck  = ck_raw  & PHASE_MASK;
        stb = stb_raw & PHASE_MASK;
    end

endmodule

`default_nettype wire

// File: rtl/phase_sequencer.sv
// ============================================================================
// Module  : phase_sequencer
// Brief   : PDP-8 major-state/phase generator: fetch, ck/stb execute phases,
//           run/halt, runaway detection, instruction counter.
//           Optional single-step start enabled by PHASE_SEQ_STEP_EN.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module phase_sequencer
    import pdp8_seq_pkg::*;
#(
    parameter int NPHASES = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    phase_sequencer_if.master   bus
);

    localparam logic [2:0] LAST_IDX = 3'(NPHASES - 1);

    seq_state_t          state_q, state_d;
    logic                seq_err_q, seq_err_d;
    logic [ICOUNT_W-1:0] icount_q, icount_d;
    logic                step_mode_q, step_mode_d;

`ifdef PHASE_SEQ_STEP_EN
    logic step_start;
    assign step_start = bus.step && !bus.halt_req;
`else
    logic step_start;
    logic unused_step;
    assign step_start  = 1'b0;
    assign unused_step = bus.step;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            seq_err_q   <= 1'b0;
            icount_q    <= '0;
            step_mode_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            seq_err_q   <= seq_err_d;
            icount_q    <= icount_d;
            step_mode_q <= step_mode_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        seq_err_d   = seq_err_q;
        icount_d    = icount_q;
        step_mode_d = step_mode_q;
        case (state_q)
            IDLE: begin
                // run has priority so a step while running is a plain start
                if (bus.run && !bus.halt_req) begin
                    state_d     = FCK;
                    seq_err_d   = 1'b0;
                    step_mode_d = 1'b0;
                end else if (step_start) begin
                    state_d     = FCK;
                    seq_err_d   = 1'b0;
                    step_mode_d = 1'b1;
                end
            end
            FCK: begin
                if (bus.mem_ready) begin
                    state_d = FSTB;
                end
            end
            FSTB: state_d = C1;
            C1, C2, C3, C4, C5, C6: begin
                if (bus.done) begin
                    icount_d = icount_q + ICOUNT_W'(1);
                    if (step_mode_q || bus.halt_req || !bus.run) begin
                        state_d = IDLE;
                    end else begin
                        state_d = FCK;
                    end
                end else begin
                    state_d = seq_state_t'(state_q + 4'd1);
                end
            end
            S1, S2, S3, S4, S5, S6: begin
                // Strobe of the last configured phase with no done: runaway.
                if (seq_phase_idx(state_q) == LAST_IDX) begin
                    state_d   = IDLE;
                    seq_err_d = 1'b1;
                end else begin
                    state_d = seq_state_t'(state_q + 4'd1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    seq_phase_decode #(
        .NPHASES (NPHASES)
    ) u_decode (
        .state     (state_q),
        .fetch_ck  (bus.fetch_ck),
        .fetch_stb (bus.fetch_stb),
        .ck        (bus.ck),
        .stb       (bus.stb),
        .running   (bus.running)
    );

    assign bus.seq_err = seq_err_q;
    assign bus.icount  = icount_q;

endmodule

`default_nettype wire
